// File: rtl/uart_tx_arbiter_if.sv
// Requester and UART register-port signals of the UART transmit arbiter.
// The arbiter uses the master view; requesters and the UART model use the slave view.
interface uart_tx_arbiter_if #(
    parameter int N = 4
);
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_last;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [3:0]     uart_div_we;
    logic [31:0]    uart_div_di;
    logic           uart_dat_we;
    logic [31:0]    uart_dat_di;
    logic           uart_dat_wait;
    logic [N-1:0]   grant;
    logic           busy;

    modport master (
        input  req_valid, req_last, req_data, uart_dat_wait,
        output req_ready, uart_div_we, uart_div_di, uart_dat_we, uart_dat_di, grant, busy
    );

    modport slave (
        output req_valid, req_last, req_data, uart_dat_wait,
        input  req_ready, uart_div_we, uart_div_di, uart_dat_we, uart_dat_di, grant, busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Per-packet round-robin arbiter in front of the UART data port; writes the baud divider once after reset.
// Build macro UART_ARB_TAG_EN: prefix every packet with tag byte 8'h80|requester index.
module uart_tx_arbiter #(
    parameter int N        = 4,
    parameter int DIV_INIT = 104,
    parameter int HOLD_MAX = 255
) (
    input  logic              clk,
    input  logic              resetn,
    uart_tx_arbiter_if.master bus
);
    localparam int         IW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX - 1);

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_IDLE = 2'd1,
        S_SEND = 2'd2
`ifdef UART_ARB_TAG_EN
        , S_TAG = 2'd3
`endif
    } state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [7:0]    hold_q, hold_d;
    logic [3:0]    div_we_q, div_we_d;
    logic [31:0]   div_di_q, div_di_d;

    logic          found_s;
    logic [IW-1:0] win_s;
    logic [IW-1:0] cand_s;
    logic          hit_s;
    logic [7:0]    sel_byte_s;
    logic          dat_we_s;
    logic [31:0]   dat_di_s;
    logic [N-1:0]  ready_s;

    // Round-robin scan starting one past the last winner; ptr_q also names the current owner.
    always_comb begin
        found_s = 1'b0;
        win_s   = ptr_q;
        cand_s  = ptr_q;
        hit_s   = 1'b0;
        for (int k = 1; k <= N; k++) begin
            cand_s  = IW'((int'(ptr_q) + k) % N);
            hit_s   = bus.req_valid[cand_s];
            win_s   = (!found_s && hit_s) ? cand_s : win_s;
            found_s = found_s | hit_s;
        end
    end

    assign sel_byte_s = bus.req_data[{ptr_q, 3'b000} +: 8];

    // Next-state and handshake outputs.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        hold_d   = hold_q;
        div_we_d = 4'h0;
        div_di_d = 32'h0;
        dat_we_s = 1'b0;
        dat_di_s = 32'h0;
        ready_s  = '0;
        case (state_q)
            S_INIT: begin
                div_we_d = 4'hF;
                div_di_d = 32'(DIV_INIT);
                state_d  = S_IDLE;
            end
            S_IDLE: begin
                hold_d = 8'h00;
                if (found_s) begin
                    grant_d = N'(1) << win_s;
                    ptr_d   = win_s;
`ifdef UART_ARB_TAG_EN
                    state_d = S_TAG;
`else
                    state_d = S_SEND;
`endif
                end else begin
                    grant_d = '0;
                end
            end
`ifdef UART_ARB_TAG_EN
            S_TAG: begin
                dat_we_s = 1'b1;
                dat_di_s = {24'h0, 8'h80 | 8'(ptr_q)};
                if (!bus.uart_dat_wait) begin
                    state_d = S_SEND;
                end else begin
                    state_d = S_TAG;
                end
            end
`endif
            S_SEND: begin
                dat_we_s       = bus.req_valid[ptr_q];
                dat_di_s       = {24'h0, sel_byte_s};
                ready_s[ptr_q] = bus.req_valid[ptr_q] && !bus.uart_dat_wait;
                if (ready_s[ptr_q]) begin
                    hold_d = 8'h00;
                    if (bus.req_last[ptr_q]) begin
                        state_d = S_IDLE;
                        grant_d = '0;
                    end else begin
                        state_d = S_SEND;
                    end
                end else if (bus.req_valid[ptr_q]) begin
                    // A stalled but present byte is not an idle cycle.
                    hold_d = 8'h00;
                end else if (hold_q >= HOLD_LIM) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    hold_d  = 8'h00;
                end else if (hold_q != 8'hFF) begin
                    hold_d = hold_q + 8'd1;
                end else begin
                    hold_d = hold_q;
                end
            end
            default: begin
                state_d = S_INIT;
                grant_d = '0;
            end
        endcase
    end

    // State and divider-write registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_INIT;
            grant_q  <= '0;
            ptr_q    <= IW'(N - 1);
            hold_q   <= 8'h00;
            div_we_q <= 4'h0;
            div_di_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            hold_q   <= hold_d;
            div_we_q <= div_we_d;
            div_di_q <= div_di_d;
        end
    end

    assign bus.req_ready   = ready_s;
    assign bus.uart_dat_we = dat_we_s;
    assign bus.uart_dat_di = dat_di_s;
    assign bus.uart_div_we = div_we_q;
    assign bus.uart_div_di = div_di_q;
    assign bus.grant       = grant_q;
    assign bus.busy        = (state_q != S_IDLE) || (div_we_q != 4'h0);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: round-robin vector table plus hand sequences, UART bytes checked by a scoreboard.
module tb_uart_tx_arbiter;
`ifdef UART_ARB_TAG_EN
    localparam bit TAG = 1'b1;
`else
    localparam bit TAG = 1'b0;
`endif

    logic clk;
    logic resetn;

    uart_tx_arbiter_if #(.N(4)) bus_if ();

    uart_tx_arbiter #(.N(4), .DIV_INIT(104), .HOLD_MAX(255)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_if.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         idx;
        bit         tag;
    } exp_t;

    typedef struct {
        logic [3:0]  mask;
        logic [15:0] order;
    } rr_vec_t;

    exp_t       exp_q[$];
    rr_vec_t    vecs[9];
    logic [8:0] src_mem [4][16];
    int         src_wr [4];
    int         src_rd [4];
    int         total;
    int         passed;

    logic        s_we;
    logic [31:0] s_di;
    logic [3:0]  s_grant;
    logic [3:0]  s_ready;
    logic        s_busy;
    logic [3:0]  s_div_we;
    logic [31:0] s_div_di;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive_srcs();
        for (int i = 0; i < 4; i++) begin
            if (src_rd[i] < src_wr[i]) begin
                bus_if.req_valid[i]       = 1'b1;
                bus_if.req_last[i]        = src_mem[i][src_rd[i]][8];
                bus_if.req_data[i*8 +: 8] = src_mem[i][src_rd[i]][7:0];
            end else begin
                bus_if.req_valid[i]       = 1'b0;
                bus_if.req_last[i]        = 1'b0;
                bus_if.req_data[i*8 +: 8] = 8'h00;
            end
        end
    endtask

    task automatic load(input int i, input logic [7:0] b, input logic last);
        if (src_rd[i] == src_wr[i]) begin
            src_rd[i] = 0;
            src_wr[i] = 0;
        end
        src_mem[i][src_wr[i]] = {last, b};
        src_wr[i]++;
        drive_srcs();
    endtask

    task automatic clear_srcs();
        for (int i = 0; i < 4; i++) begin
            src_rd[i] = 0;
            src_wr[i] = 0;
        end
        drive_srcs();
    endtask

    function automatic bit srcs_pending();
        bit p = 1'b0;
        for (int i = 0; i < 4; i++) p = p | (src_rd[i] < src_wr[i]);
        return p;
    endfunction

    task automatic push_exp(input int i, input logic [7:0] b);
        exp_t e;
        e.data = b; e.idx = i; e.tag = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic push_tag(input int i);
        exp_t e;
        e.data = 8'h80 | 8'(i); e.idx = i; e.tag = 1'b1;
        if (TAG) exp_q.push_back(e);
    endtask

    // One clock: sample at negedge, score an accepted byte, advance the requester models after the edge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        s_we     = bus_if.uart_dat_we;
        s_di     = bus_if.uart_dat_di;
        s_grant  = bus_if.grant;
        s_ready  = bus_if.req_ready;
        s_busy   = bus_if.busy;
        s_div_we = bus_if.uart_div_we;
        s_div_di = bus_if.uart_div_di;
        if (s_we && !bus_if.uart_dat_wait) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL sb_unexpected: got byte %0h expected none", s_di[7:0]);
            end else begin
                e = exp_q.pop_front();
                chk("sb_byte", s_di, {24'h0, e.data});
                chk("sb_grant", {28'h0, s_grant}, 32'(1) << e.idx);
                chk("sb_ready", {28'h0, s_ready}, e.tag ? 32'h0 : (32'(1) << e.idx));
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) if (s_ready[i]) src_rd[i]++;
        drive_srcs();
    endtask

    task automatic wait_drain(input int bound);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || srcs_pending()) && n < bound) begin
            step();
            n++;
        end
        if (exp_q.size() != 0 || srcs_pending()) begin
            total++;
            $display("FAIL drain_timeout: got %0d bytes outstanding expected 0", exp_q.size());
        end
        step();
        step();
        chk("drain_idle_grant", {28'h0, s_grant}, 32'h0);
    endtask

    task automatic release_and_check();
        resetn = 1'b1;
        step();
        chk("init_pre_div_we", {28'h0, s_div_we}, 32'h0);
        step();
        chk("init_div_we", {28'h0, s_div_we}, 32'hF);
        chk("init_div_di", s_div_di, 32'd104);
        chk("init_busy", {31'h0, s_busy}, 32'h1);
        step();
        chk("init_done_div_we", {28'h0, s_div_we}, 32'h0);
        chk("init_done_busy", {31'h0, s_busy}, 32'h0);
    endtask

    initial begin
        logic [7:0] seq_a[$];
        logic [7:0] stall_b;
        int         n, idx, cnt;
        bit         ok;

        clk = 1'b0; resetn = 1'b0; total = 0; passed = 0;
        bus_if.uart_dat_wait = 1'b0;
        clear_srcs();

        // {mask, order}: order nibble k is the k-th requester served, derived from the pointer left by the previous row.
        vecs[0] = '{4'b0111, 16'h0210};
        vecs[1] = '{4'b0001, 16'h0000};
        vecs[2] = '{4'b1111, 16'h0321};
        vecs[3] = '{4'b1010, 16'h0031};
        vecs[4] = '{4'b0110, 16'h0021};
        vecs[5] = '{4'b1001, 16'h0003};
        vecs[6] = '{4'b0100, 16'h0002};
        vecs[7] = '{4'b1011, 16'h0103};
        vecs[8] = '{4'b0101, 16'h0002};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {28'h0, bus_if.req_ready}, 32'h0);
        chk("rst_div_we", {28'h0, bus_if.uart_div_we}, 32'h0);
        chk("rst_div_di", bus_if.uart_div_di, 32'h0);
        chk("rst_dat_we", {31'h0, bus_if.uart_dat_we}, 32'h0);
        chk("rst_dat_di", bus_if.uart_dat_di, 32'h0);
        chk("rst_grant", {28'h0, bus_if.grant}, 32'h0);
        chk("rst_busy", {31'h0, bus_if.busy}, 32'h1);
        release_and_check();

        for (int v = 0; v < 9; v++) begin
            n = $countones(vecs[v].mask);
            for (int k = 0; k < n; k++) begin
                idx = int'(vecs[v].order[4*k +: 4]);
                push_tag(idx);
                push_exp(idx, {4'(v), 4'(idx)});
            end
            for (int i = 0; i < 4; i++)
                if (vecs[v].mask[i]) load(i, {4'(v), 4'(i)}, 1'b1);
            wait_drain(100);
        end

        // Three-byte packet back to back, one-cycle grant latency.
        if (TAG) seq_a.push_back(8'h80);
        seq_a.push_back(8'h41); seq_a.push_back(8'h42); seq_a.push_back(8'h43);
        push_tag(0);
        push_exp(0, 8'h41); push_exp(0, 8'h42); push_exp(0, 8'h43);
        load(0, 8'h41, 1'b0); load(0, 8'h42, 1'b0); load(0, 8'h43, 1'b1);
        step();
        chk("lat_idle_we", {31'h0, s_we}, 32'h0);
        foreach (seq_a[k]) begin
            step();
            chk("seqa_we", {31'h0, s_we}, 32'h1);
            chk("seqa_di", s_di, {24'h0, seq_a[k]});
            chk("seqa_grant", {28'h0, s_grant}, 32'h1);
        end
        step();
        chk("seqa_grant_clr", {28'h0, s_grant}, 32'h0);
        wait_drain(20);

        // UART stall for 20 cycles: strobe and data held, no ready, no timeout.
        stall_b = TAG ? 8'h81 : 8'h41;
        bus_if.uart_dat_wait = 1'b1;
        push_tag(1);
        push_exp(1, 8'h41);
        load(1, 8'h41, 1'b1);
        step();
        ok = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            if (!(s_we && s_di == {24'h0, stall_b} && s_ready == 4'h0 && s_grant == 4'b0010)) ok = 1'b0;
        end
        chk("stall_hold", {31'h0, ok}, 32'h1);
        bus_if.uart_dat_wait = 1'b0;
        wait_drain(20);

        // Requester 3 abandons its packet; requester 1 waits behind it.
        push_tag(3); push_exp(3, 8'h55);
        push_tag(1); push_exp(1, 8'h66);
        load(3, 8'h55, 1'b0);
        load(1, 8'h66, 1'b1);
        n = TAG ? 2 : 1;
        cnt = 0;
        while (exp_q.size() > n && cnt < 20) begin
            step();
            cnt++;
        end
        chk("hold_first_byte", exp_q.size(), n);
        cnt = 0;
        for (int c = 0; c < 400; c++) begin
            step();
            if (s_grant != 4'b1000) break;
            cnt++;
        end
        chk("hold_timeout_cycles", cnt, 32'd255);
        wait_drain(20);

        // Tag-build case: single-byte packet from requester 2.
        push_tag(2);
        push_exp(2, 8'hAA);
        load(2, 8'hAA, 1'b1);
        wait_drain(20);

        // Reset mid-packet, then the pointer must start again at N-1.
        push_tag(0);
        push_exp(0, 8'h11);
        load(0, 8'h11, 1'b0); load(0, 8'h12, 1'b0); load(0, 8'h13, 1'b1);
        step();
        step();
        resetn = 1'b0;
        #1;
        chk("midrst_grant", {28'h0, bus_if.grant}, 32'h0);
        chk("midrst_dat_we", {31'h0, bus_if.uart_dat_we}, 32'h0);
        chk("midrst_busy", {31'h0, bus_if.busy}, 32'h1);
        chk("midrst_ready", {28'h0, bus_if.req_ready}, 32'h0);
        exp_q.delete();
        clear_srcs();
        @(posedge clk);
        #1;
        release_and_check();
        push_tag(0); push_exp(0, 8'hC0);
        push_tag(3); push_exp(3, 8'hC3);
        load(0, 8'hC0, 1'b1);
        load(3, 8'hC3, 1'b1);
        wait_drain(40);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
